// File: rtl/input_filter_image.sv
// rtl/input_filter_image.sv - input synchroniser, debounce filter and snapshot image with serial readout
// Optional active-low channel support via `define INPUT_INVERT_EN (adds INV port).
module input_filter_image #(
    parameter int N_IN      = 16,
    parameter int A_W       = 4,
    parameter int PRESC_DIV = 100,
    parameter int FILT_LEN  = 4
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic [N_IN-1:0] RAW,
`ifdef INPUT_INVERT_EN
    input  logic [N_IN-1:0] INV,
`endif
    input  logic            SNAP,
    output logic            SNAP_ACK,
    input  logic [A_W-1:0]  ADDR,
    output logic            BIT_OUT,
    output logic [N_IN-1:0] IMAGE,
    output logic [N_IN-1:0] STABLE,
    output logic            CHG
);

    localparam int FILT_W = 4;
    localparam int IW     = ((1 << A_W) > N_IN) ? (1 << A_W) : N_IN;

    logic [N_IN-1:0]              sync1_q, sync1_d;
    logic [N_IN-1:0]              sync2_q, sync2_d;
    logic [15:0]                  presc_q, presc_d;
    logic [N_IN-1:0][FILT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]              stable_q, stable_d;
    logic [N_IN-1:0]              image_q, image_d;
    logic                         bit_q, bit_d;
    logic                         ack_q, ack_d;
    logic                         chg_q, chg_d;

    logic [N_IN-1:0]              filt_in;
    logic                         tick;
    logic [IW-1:0]                img_ext;

    always_comb begin
`ifdef INPUT_INVERT_EN
        filt_in = sync2_q ^ INV;
`else
        filt_in = sync2_q;
`endif
        sync1_d  = RAW;
        sync2_d  = sync1_q;
        tick     = (presc_q == 16'(PRESC_DIV - 1));
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        stable_d = stable_q;
        cnt_d    = cnt_q;

        // A new level is accepted only after FILT_LEN consecutive mismatching ticks.
        if (tick) begin
            for (int i = 0; i < N_IN; i++) begin
                if (filt_in[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == FILT_W'(FILT_LEN - 1)) begin
                    stable_d[i] = filt_in[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + FILT_W'(1);
                end
            end
        end

        image_d = SNAP ? stable_q : image_q;
        ack_d   = SNAP;
        // A toggle in the snapshot cycle keeps CHG set.
        if (stable_d != stable_q) begin
            chg_d = 1'b1;
        end else if (SNAP) begin
            chg_d = 1'b0;
        end else begin
            chg_d = chg_q;
        end

        img_ext = IW'(image_q);
        bit_d   = (int'(ADDR) < N_IN) ? img_ext[ADDR] : 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            image_q  <= '0;
            bit_q    <= 1'b0;
            ack_q    <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            image_q  <= image_d;
            bit_q    <= bit_d;
            ack_q    <= ack_d;
            chg_q    <= chg_d;
        end
    end

    assign SNAP_ACK = ack_q;
    assign BIT_OUT  = bit_q;
    assign IMAGE    = image_q;
    assign STABLE   = stable_q;
    assign CHG      = chg_q;

endmodule

// File: tb/tb_input_filter_image.sv
// tb/tb_input_filter_image.sv - self-checking bench for input_filter_image
module tb_input_filter_image;

    localparam int N = 12;
    localparam int P = 4;
    localparam int F = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         clr = 1'b1;
    logic [N-1:0] raw = '0;
    logic         snap = 1'b0;
    logic [3:0]   addr = '0;
    logic         snap_ack, bit_out, chg;
    logic [N-1:0] image, stable;

    logic [15:0]  raw_def = '0;
    logic         d_ack, d_bit, d_chg;
    logic [15:0]  d_image, d_stable;
`ifdef INPUT_INVERT_EN
    logic [N-1:0] inv = '0;
    logic [15:0]  inv_def = '0;
`endif

    int checks = 0;
    int errors = 0;

    input_filter_image #(.N_IN(N), .A_W(4), .PRESC_DIV(P), .FILT_LEN(F)) u_dut (
        .CLK(clk), .CLR(clr), .RAW(raw),
`ifdef INPUT_INVERT_EN
        .INV(inv),
`endif
        .SNAP(snap), .SNAP_ACK(snap_ack), .ADDR(addr), .BIT_OUT(bit_out),
        .IMAGE(image), .STABLE(stable), .CHG(chg)
    );

    input_filter_image u_def (
        .CLK(clk), .CLR(clr), .RAW(raw_def),
`ifdef INPUT_INVERT_EN
        .INV(inv_def),
`endif
        .SNAP(1'b0), .SNAP_ACK(d_ack), .ADDR(4'd0), .BIT_OUT(d_bit),
        .IMAGE(d_image), .STABLE(d_stable), .CHG(d_chg)
    );

    // Reference model: raw delayed two edges, run-length of mismatching tick samples per channel.
    logic [N-1:0] m_h1, m_h2, m_stable, m_image, m_nxt, m_shift;
    logic         m_chg, m_ack, m_bit;
    int           m_phase;
    int           m_run [N];

    always @(posedge clk) begin
        if (clr) begin
            m_h1 = '0; m_h2 = '0; m_stable = '0; m_image = '0;
            m_chg = 0; m_ack = 0; m_bit = 0; m_phase = 0;
            foreach (m_run[i]) m_run[i] = 0;
        end else begin
            m_nxt = m_stable;
            if (m_phase == P - 1) begin
                for (int i = 0; i < N; i++) begin
                    if (m_h2[i] != m_stable[i]) begin
                        m_run[i] = m_run[i] + 1;
                        if (m_run[i] == F) begin
                            m_nxt[i] = m_h2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_shift = m_image >> addr;
            m_bit   = (int'(addr) < N) ? m_shift[0] : 1'b0;
            if (m_nxt != m_stable) m_chg = 1'b1;
            else if (snap)         m_chg = 1'b0;
            m_ack = snap;
            if (snap) m_image = m_stable;
            m_phase  = (m_phase + 1) % P;
            m_h2     = m_h1;
            m_h1     = raw;
            m_stable = m_nxt;
        end
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(negedge clk);
        clr = 1'b1; snap = 1'b0; addr = '0;
        step();
        step();
        clr = 1'b0;
        raw = r;
    endtask

    task automatic test_reset;
        @(negedge clk);
        clr = 1'b1; raw = '1; raw_def = 16'hFFFF;
        step();
        step();
        checks += 8;
        if (image !== '0)    begin errors++; $display("FAIL reset_image got %h want 0", image); end
        if (stable !== '0)   begin errors++; $display("FAIL reset_stable got %h want 0", stable); end
        if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit got %b want 0", bit_out); end
        if (chg !== 1'b0)    begin errors++; $display("FAIL reset_chg got %b want 0", chg); end
        if (snap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", snap_ack); end
        if (d_stable !== '0) begin errors++; $display("FAIL reset_def_stable got %h want 0", d_stable); end
        if (d_image !== '0)  begin errors++; $display("FAIL reset_def_image got %h want 0", d_image); end
        if (d_chg !== 1'b0)  begin errors++; $display("FAIL reset_def_chg got %b want 0", d_chg); end
        clr = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 11) begin
                checks++;
                if (stable !== '0) begin errors++; $display("FAIL early_accept got %h want 0", stable); end
            end
            if (k == 12) begin
                checks++;
                if (stable !== {N{1'b1}}) begin errors++; $display("FAIL accept_12 got %h want %h", stable, {N{1'b1}}); end
            end
            if (k == 399) begin
                checks++;
                if (d_stable !== 16'h0000) begin errors++; $display("FAIL def_tick_early got %h want 0000", d_stable); end
            end
            if (k == 400) begin
                checks += 2;
                if (d_stable !== 16'hFFFF) begin errors++; $display("FAIL def_tick_400 got %h want ffff", d_stable); end
                if (d_chg !== 1'b1) begin errors++; $display("FAIL def_chg got %b want 1", d_chg); end
            end
        end
    endtask

    task automatic test_debounce;
        do_reset(12'h001);
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (k < 12) begin
                if (stable !== '0 || chg !== 1'b0) begin
                    errors++; $display("FAIL debounce_early k=%0d got %h/%b want 0/0", k, stable, chg);
                end
            end else begin
                if (stable !== 12'h001 || chg !== 1'b1) begin
                    errors++; $display("FAIL debounce_accept got %h/%b want 001/1", stable, chg);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int bad;
        do_reset(12'h020);
        repeat (6) step();
        raw = '0;
        bad = 0;
        repeat (30) begin
            step();
            if (stable !== '0 || chg !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL glitch_reject got %0d bad cycles want 0", bad); end
        raw = 12'h020;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 11) begin
                checks++;
                if (stable !== '0) begin errors++; $display("FAIL glitch_cnt_restart got %h want 000", stable); end
            end
            if (k == 12) begin
                checks++;
                if (stable !== 12'h020) begin errors++; $display("FAIL glitch_reaccept got %h want 020", stable); end
            end
        end
    endtask

    task automatic test_snapshot;
        logic [15:0] exp_bits;
        int bad;
        exp_bits = 16'h00F0;
        do_reset(12'h0F0);
        repeat (12) step();
        checks++;
        if (stable !== 12'h0F0) begin errors++; $display("FAIL snap_setup got %h want 0f0", stable); end
        snap = 1'b1;
        step();
        snap = 1'b0;
        checks += 3;
        if (snap_ack !== 1'b1) begin errors++; $display("FAIL snap_ack got %b want 1", snap_ack); end
        if (image !== 12'h0F0) begin errors++; $display("FAIL snap_image got %h want 0f0", image); end
        if (chg !== 1'b0)      begin errors++; $display("FAIL snap_chg got %b want 0", chg); end
        step();
        checks++;
        if (snap_ack !== 1'b0) begin errors++; $display("FAIL snap_ack_pulse got %b want 0", snap_ack); end
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a);
            step();
            checks++;
            if (bit_out !== exp_bits[a]) begin
                errors++; $display("FAIL readout a=%0d got %b want %b", a, bit_out, exp_bits[a]);
            end
        end
        bad = 0;
        repeat (40) begin
            raw = N'($urandom);
            step();
            if (image !== 12'h0F0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL image_frozen got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_simul;
        do_reset(12'h0F0);
        repeat (12) step();
        raw = 12'h0F8;
        repeat (11) step();
        checks++;
        if (stable !== 12'h0F0) begin errors++; $display("FAIL simul_pre got %h want 0f0", stable); end
        snap = 1'b1;
        step();
        snap = 1'b0;
        checks += 3;
        if (stable !== 12'h0F8) begin errors++; $display("FAIL simul_stable got %h want 0f8", stable); end
        if (image !== 12'h0F0)  begin errors++; $display("FAIL simul_image got %h want 0f0", image); end
        if (chg !== 1'b1)       begin errors++; $display("FAIL simul_chg got %b want 1", chg); end
        snap = 1'b1;
        step();
        snap = 1'b0;
        checks += 2;
        if (image !== 12'h0F8) begin errors++; $display("FAIL resnap_image got %h want 0f8", image); end
        if (chg !== 1'b0)      begin errors++; $display("FAIL resnap_chg got %b want 0", chg); end
    endtask

    task automatic test_reset_mid;
        do_reset(12'h004);
        repeat (8) step();
        addr = 4'd13;
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks += 4;
        if (stable !== '0)     begin errors++; $display("FAIL mid_stable got %h want 000", stable); end
        if (image !== '0)      begin errors++; $display("FAIL mid_image got %h want 000", image); end
        if (chg !== 1'b0)      begin errors++; $display("FAIL mid_chg got %b want 0", chg); end
        if (bit_out !== 1'b0)  begin errors++; $display("FAIL mid_bit got %b want 0", bit_out); end
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (bit_out !== 1'b0) begin errors++; $display("FAIL addr13 got %b want 0", bit_out); end
            end
            if (k == 11) begin
                checks++;
                if (stable !== '0) begin errors++; $display("FAIL mid_restart_early got %h want 000", stable); end
            end
            if (k == 12) begin
                checks++;
                if (stable !== 12'h004) begin errors++; $display("FAIL mid_restart got %h want 004", stable); end
            end
        end
    endtask

    task automatic test_random;
        do_reset(N'($urandom));
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) raw = raw ^ N'(1 << $urandom_range(0, N - 1));
            snap = ($urandom_range(0, 9) == 0);
            addr = 4'($urandom_range(0, 15));
            clr  = (c == 700);
            step();
            checks += 5;
            if (stable !== m_stable) begin errors++; $display("FAIL rnd_stable c=%0d got %h want %h", c, stable, m_stable); end
            if (image !== m_image)   begin errors++; $display("FAIL rnd_image c=%0d got %h want %h", c, image, m_image); end
            if (chg !== m_chg)       begin errors++; $display("FAIL rnd_chg c=%0d got %b want %b", c, chg, m_chg); end
            if (snap_ack !== m_ack)  begin errors++; $display("FAIL rnd_ack c=%0d got %b want %b", c, snap_ack, m_ack); end
            if (bit_out !== m_bit)   begin errors++; $display("FAIL rnd_bit c=%0d got %b want %b", c, bit_out, m_bit); end
        end
        clr = 1'b0;
        snap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_snapshot();
        test_simul();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
